// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add multiplier for the EX stage.
// A MUL instruction in EX is latched and then multiplied one multiplier bit
// per cycle. stall_o freezes IF/ID/EX until the result is ready. Every other
// ALU operation passes through without any stall.
module mul_sequencer #(
    parameter int          WIDTH  = 32,
    parameter logic [3:0]  MUL_OP = 4'b0101
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] result_reg;
    logic             done_reg;

    logic             start;
    logic [WIDTH-1:0] acc_next;

    // A new multiply may only begin from a valid, unsquashed MUL in EX.
    always_comb begin
        start = valid_i && (ALUCtrl_i == MUL_OP) && !flush_i;
    end

    // Partial-product accumulation for the current multiplier bit; wraps mod 2^WIDTH.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // Stall covers the launch cycle and every BUSY cycle; it drops in DONE so
    // the pipeline advances on that edge. Flush and reset release it at once.
    always_comb begin
        stall_o = !rst_i && !flush_i &&
                  (((state_reg == IDLE) && start) || (state_reg == BUSY));
    end

    // done_o is the registered DONE flag, masked when the MUL is being squashed.
    always_comb begin
        done_o   = done_reg && !flush_i;
        result_o = result_reg;
    end

    // Sequencer FSM with its datapath registers and registered result/done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        mcand_reg  <= data1_i;
                        mplier_reg <= data2_i;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        // Squashed MUL: abandon the partial product, keep the old result.
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + 1'b1;
                        // Always WIDTH iterations; no early exit on a zero multiplier.
                        if (cnt_reg == CNT_LAST) begin
                            result_reg <= acc_next;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The finished MUL is still in EX here, so start is not sampled.
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
